dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Responder end of the core data-memory port: accepts dmem_* requests, drives dmem_read_data/dmem_wait.
// - Bridges to a word-wide req/ack memory bus (SRAM, peripherals) with byte-lane steering.
// - Sits between core and data RAM/peripheral fabric; core owns sign extension, this block returns
//   lane-aligned, zero-extended data.
// PARAMETERS
// - ADDR_WIDTH   32   byte address width; mem_addr is ADDR_WIDTH-2 bits (word address)
// - ACK_TIMEOUT  255  cycles in ACCESS without mem_ack before bus error; 0 = no timeout
// PORTS
// - clk                 in   1   clock
// - reset_n             in   1   asynchronous active-low reset
// - dmem_address        in   32  byte address of request
// - dmem_enable         in   1   request strobe, sampled at rising edge
// - dmem_write_data     in   32  store data, right-aligned
// - dmem_write_enable   in   1   store request
// - dmem_write_mode     in   3   000 SB, 001 SH, 010 SW
// - dmem_read_enable    in   1   load request
// - dmem_read_mode      in   3   000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
// - dmem_read_data      out  32  load data, lane-shifted to bit 0, upper bits zero
// - dmem_wait           out  1   stall core; access in progress
// - bus_error           out  1   one-cycle pulse on ack timeout
// - mem_req             out  1   bus request, held until mem_ack
// - mem_addr            out  ADDR_WIDTH-2  word address
// - mem_we              out  1   write cycle
// - mem_wstrb           out  4   byte strobes
// - mem_wdata           out  32  lane-steered write data
// - mem_rdata           in   32  read word, valid with mem_ack
// - mem_ack             in   1   completion, single cycle
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; read-data and timeout registers 0. Reset mid-access drops mem_req
//   asynchronously; a late mem_ack in IDLE is ignored.
// - Accept: rising edge with dmem_enable && (read_enable || write_enable) && !dmem_wait
//   -> latch addr/data/modes, go ACCESS. Write has priority if both set (read_data not updated).
// - ACCESS: mem_req=1, mem_addr/mem_we/mem_wstrb/mem_wdata stable from latched request.
// - dmem_wait = (state==ACCESS) && !mem_ack (combinational); zero-wait memory gives no stall.
// - dmem_read_data = (ACCESS && mem_ack && read) ? steered mem_rdata : held register;
//   register loads on that ack.
// - On mem_ack: new accept on same edge -> stay ACCESS, else -> IDLE.
// - Steering, a=addr[1:0]: SB strb=0001<<a, wdata=byte replicated x4; SH strb=0011<<{a[1],0},
//   wdata=half x2; SW strb=1111. Loads: data >> (8*a) (half uses a[1]), masked to 8/16/32 bits.
// - Timeout: counter clears on accept, increments in ACCESS. At ACK_TIMEOUT: bus_error pulse,
//   read register <= 0, dmem_wait drops, -> IDLE. Counter saturates, no wrap.
// - Undefined modes (011, 11x): treated as word.
// CONFIGURATION
// - DMEM_MISALIGN_CHECK_EN defined: misaligned SH/LH/LHU (a[0]) or SW/LW (a!=0) issues no mem_req;
//   output misaligned (1 bit) pulses one cycle after accept; read register <= 0; no wait.
// - Undefined: misaligned port absent; low address bits below access size are ignored (forced aligned).
// TESTING
// - LW 0x100, mem_ack same cycle, mem_rdata=0xDEADBEEF -> wait never 1, read_data=0xDEADBEEF next cycle.
// - SB 0x203 data 0x000000A5 -> mem_addr=0x80, wstrb=1000, wdata=0xA5A5A5A5, mem_we=1.
// - LHU 0x42, ack after 3 cycles, rdata=0x12345678 -> wait high 3 cycles, read_data=0x00001234.
// - ACK_TIMEOUT=4, no ack -> wait high 4 cycles, bus_error pulse, read_data=0, state IDLE.
// - reset_n low mid-ACCESS -> mem_req/wait 0 immediately; ack after release ignored.
// - DMEM_MISALIGN_CHECK_EN, LW 0x101 -> no mem_req, misaligned pulse, read_data=0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module      : dmem_if / mem_bus_if
// Description : Core data-memory port and word-wide req/ack memory bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_if;
    logic [31:0] dmem_address;
    logic        dmem_enable;
    logic [31:0] dmem_write_data;
    logic        dmem_write_enable;
    logic [2:0]  dmem_write_mode;
    logic        dmem_read_enable;
    logic [2:0]  dmem_read_mode;
    logic [31:0] dmem_read_data;
    logic        dmem_wait;

    modport master (
        output dmem_address, dmem_enable, dmem_write_data, dmem_write_enable,
               dmem_write_mode, dmem_read_enable, dmem_read_mode,
        input  dmem_read_data, dmem_wait
    );
    modport slave (
        input  dmem_address, dmem_enable, dmem_write_data, dmem_write_enable,
               dmem_write_mode, dmem_read_enable, dmem_read_mode,
        output dmem_read_data, dmem_wait
    );
endinterface

interface mem_bus_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic [ADDR_WIDTH-3:0] mem_addr;
    logic                  mem_we;
    logic [3:0]            mem_wstrb;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata,
        input  mem_rdata, mem_ack
    );
    modport slave (
        input  mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Core data-memory responder bridging to a req/ack word bus
//               with byte-lane steering. Optional misalignment trap enabled
//               by defining DMEM_MISALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      reset_n,
    dmem_if.slave     dmem,
    mem_bus_if.master mem,
    output logic      bus_error
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    output logic      misaligned
`endif
);

    localparam int             C_CNT_W   = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = {C_CNT_W{1'b1}};
    localparam logic [C_CNT_W-1:0] C_TMO_LAST = C_CNT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);
    localparam logic [1:0]     C_SZ_BYTE = 2'd0;
    localparam logic [1:0]     C_SZ_HALF = 2'd1;
    localparam logic [1:0]     C_SZ_WORD = 2'd2;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic                  r_read;
    logic [1:0]            r_size;
    logic [3:0]            r_wstrb;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic [C_CNT_W-1:0]    r_tcnt;
    logic                  r_bus_error;

    logic        w_accept;
    logic        w_go;
    logic        w_misalign;
    logic        w_timeout;
    logic        w_rd_ack;
    logic [1:0]  w_size;
    logic [1:0]  w_lane;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic [31:0] w_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_lane         = dmem.dmem_address[1:0];
    assign dmem.dmem_wait = (r_state == ST_ACCESS) && !mem.mem_ack;
    assign w_accept       = dmem.dmem_enable && !dmem.dmem_wait
                            && (dmem.dmem_read_enable || dmem.dmem_write_enable);

    // Stores take priority, so the size comes from the write mode when both are set
    always_comb begin
        w_size = C_SZ_WORD;
        if (dmem.dmem_write_enable) begin
            case (dmem.dmem_write_mode)
                3'b000:  w_size = C_SZ_BYTE;
                3'b001:  w_size = C_SZ_HALF;
                default: w_size = C_SZ_WORD;
            endcase
        end else begin
            case (dmem.dmem_read_mode)
                3'b000, 3'b100: w_size = C_SZ_BYTE;
                3'b001, 3'b101: w_size = C_SZ_HALF;
                default:        w_size = C_SZ_WORD;
            endcase
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_misalign = ((w_size == C_SZ_HALF) && w_lane[0])
                        || ((w_size == C_SZ_WORD) && (w_lane != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif
    assign w_go = w_accept && !w_misalign;

    always_comb begin
        w_strb  = 4'b1111;
        w_wdata = dmem.dmem_write_data;
        case (w_size)
            C_SZ_BYTE: begin
                w_strb  = 4'b0001 << w_lane;
                w_wdata = {4{dmem.dmem_write_data[7:0]}};
            end
            C_SZ_HALF: begin
                w_strb  = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{dmem.dmem_write_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_byte = 8'(mem.mem_rdata >> {r_addr[1:0], 3'b000});
    assign w_half = 16'(mem.mem_rdata >> {r_addr[1], 4'b0000});

    always_comb begin
        case (r_size)
            C_SZ_BYTE: w_load = {24'h0, w_byte};
            C_SZ_HALF: w_load = {16'h0, w_half};
            default:   w_load = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An ack always wins over a timeout landing on the same cycle
    always_comb begin
        w_state_next = r_state;
        w_rd_ack     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (mem.mem_ack) begin
                    w_rd_ack     = r_read;
                    w_state_next = w_go ? ST_ACCESS : ST_IDLE;
                end else if ((ACK_TIMEOUT != 0) && (r_tcnt == C_TMO_LAST)) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_read      <= 1'b0;
            r_size      <= C_SZ_WORD;
            r_wstrb     <= 4'b0000;
            r_wdata     <= 32'h0;
            r_rdata     <= 32'h0;
            r_tcnt      <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_bus_error <= w_timeout;
            if (w_go) begin
                r_addr  <= dmem.dmem_address[ADDR_WIDTH-1:0];
                r_we    <= dmem.dmem_write_enable;
                r_read  <= !dmem.dmem_write_enable;
                r_size  <= w_size;
                r_wstrb <= dmem.dmem_write_enable ? w_strb : 4'b0000;
                r_wdata <= w_wdata;
                r_tcnt  <= '0;
            end else if ((r_state == ST_ACCESS) && !mem.mem_ack && (r_tcnt != C_CNT_MAX)) begin
                r_tcnt <= r_tcnt + C_CNT_W'(1);
            end
            if ((w_accept && w_misalign) || w_timeout) begin
                r_rdata <= 32'h0;
            end else if (w_rd_ack) begin
                r_rdata <= w_load;
            end
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    logic r_misaligned;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_accept && w_misalign;
        end
    end

    assign misaligned = r_misaligned;
`endif

    assign dmem.dmem_read_data = w_rd_ack ? w_load : r_rdata;
    assign bus_error           = r_bus_error;
    assign mem.mem_req         = (r_state == ST_ACCESS);
    assign mem.mem_addr        = r_addr[ADDR_WIDTH-1:2];
    assign mem.mem_we          = r_we;
    assign mem.mem_wstrb       = r_wstrb;
    assign mem.mem_wdata       = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder with a lane/size model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    logic clk;
    logic reset_n;
    logic bus_error;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic misaligned;
`endif

    dmem_if                     dmem_bus ();
    mem_bus_if #(.ADDR_WIDTH(32)) mbus   ();

    dmem_responder #(.ADDR_WIDTH(32), .ACK_TIMEOUT(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dmem      (dmem_bus),
        .mem       (mbus),
        .bus_error (bus_error)
`ifdef DMEM_MISALIGN_CHECK_EN
        ,
        .misaligned(misaligned)
`endif
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_rd = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

    // Starts and ends at posedge+1 with mem_req low; delay = cycles before mem_ack
    task automatic run_access(input bit we, input bit re, input logic [2:0] mode,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int delay, input logic [31:0] rd);
        int          sz;
        int          a;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_load;
        a = int'(addr[1:0]);
        if (we) sz = (mode == 3'd0) ? 1 : (mode == 3'd1) ? 2 : 4;
        else    sz = (mode == 3'd0 || mode == 3'd4) ? 1 : (mode == 3'd1 || mode == 3'd5) ? 2 : 4;
        case (sz)
            1: begin
                e_strb  = 4'(1 << a);
                e_wdata = {24'h0, wd[7:0]} * 32'h01010101;
                e_load  = (rd >> (8 * a)) & 32'hFF;
            end
            2: begin
                e_strb  = 4'(3 << ((a / 2) * 2));
                e_wdata = {16'h0, wd[15:0]} * 32'h00010001;
                e_load  = (rd >> (16 * (a / 2))) & 32'hFFFF;
            end
            default: begin
                e_strb  = 4'hF;
                e_wdata = wd;
                e_load  = rd;
            end
        endcase
        dmem_bus.dmem_address      = addr;
        dmem_bus.dmem_write_data   = wd;
        dmem_bus.dmem_write_enable = we;
        dmem_bus.dmem_read_enable  = re;
        dmem_bus.dmem_write_mode   = mode;
        dmem_bus.dmem_read_mode    = mode;
        dmem_bus.dmem_enable       = 1'b1;
        mbus.mem_rdata             = $urandom;
        @(posedge clk); #1;
        dmem_bus.dmem_enable       = 1'b0;
        dmem_bus.dmem_write_enable = 1'b0;
        dmem_bus.dmem_read_enable  = 1'b0;
        n_cmp++; if (mbus.mem_req !== 1'b1) begin n_err++; $display("FAIL req_high: got %b want 1", mbus.mem_req); end
        n_cmp++; if (mbus.mem_addr !== addr[31:2]) begin n_err++; $display("FAIL mem_addr: got %h want %h", mbus.mem_addr, addr[31:2]); end
        n_cmp++; if (mbus.mem_we !== we) begin n_err++; $display("FAIL mem_we: got %b want %b", mbus.mem_we, we); end
        if (we) begin
            n_cmp++; if (mbus.mem_wstrb !== e_strb) begin n_err++; $display("FAIL wstrb: got %b want %b", mbus.mem_wstrb, e_strb); end
            n_cmp++; if (mbus.mem_wdata !== e_wdata) begin n_err++; $display("FAIL wdata: got %h want %h", mbus.mem_wdata, e_wdata); end
        end
        for (int i = 0; i < delay; i++) begin
            n_cmp++; if (dmem_bus.dmem_wait !== 1'b1) begin n_err++; $display("FAIL wait_high cyc%0d: got %b want 1", i, dmem_bus.dmem_wait); end
            @(posedge clk); #1;
        end
        mbus.mem_ack   = 1'b1;
        mbus.mem_rdata = rd;
        #1;
        n_cmp++; if (dmem_bus.dmem_wait !== 1'b0) begin n_err++; $display("FAIL wait_on_ack: got %b want 0", dmem_bus.dmem_wait); end
        if (re && !we) begin
            exp_rd = e_load;
            n_cmp++; if (dmem_bus.dmem_read_data !== exp_rd) begin n_err++; $display("FAIL rdata_ack: got %h want %h", dmem_bus.dmem_read_data, exp_rd); end
        end
        @(posedge clk); #1;
        mbus.mem_ack   = 1'b0;
        mbus.mem_rdata = $urandom;
        #1;
        n_cmp++; if (mbus.mem_req !== 1'b0) begin n_err++; $display("FAIL req_done: got %b want 0", mbus.mem_req); end
        n_cmp++; if (dmem_bus.dmem_read_data !== exp_rd) begin n_err++; $display("FAIL rdata_hold: got %h want %h", dmem_bus.dmem_read_data, exp_rd); end
    endtask

    task automatic test_reset();
        n_cmp++; if (mbus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", mbus.mem_req); end
        n_cmp++; if (dmem_bus.dmem_wait !== 1'b0) begin n_err++; $display("FAIL rst_wait: got %b want 0", dmem_bus.dmem_wait); end
        n_cmp++; if (dmem_bus.dmem_read_data !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", dmem_bus.dmem_read_data); end
        n_cmp++; if (bus_error !== 1'b0) begin n_err++; $display("FAIL rst_buserr: got %b want 0", bus_error); end
        n_cmp++; if ({mbus.mem_we, mbus.mem_wstrb, mbus.mem_addr, mbus.mem_wdata} !== 67'h0) begin
            n_err++; $display("FAIL rst_bus: got we=%b strb=%b addr=%h wdata=%h want all 0", mbus.mem_we, mbus.mem_wstrb, mbus.mem_addr, mbus.mem_wdata);
        end
    endtask

    task automatic test_zero_wait_load();
        run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        n_cmp++; if (dmem_bus.dmem_read_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_zero_wait: got %h want deadbeef", dmem_bus.dmem_read_data); end
    endtask

    task automatic test_store_byte();
        run_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h000000A5, 1, 32'h0);
    endtask

    task automatic test_delayed_load();
        run_access(1'b0, 1'b1, 3'b101, 32'h42, 32'h0, 3, 32'h12345678);
        n_cmp++; if (dmem_bus.dmem_read_data !== 32'h00001234) begin n_err++; $display("FAIL lhu_delay: got %h want 00001234", dmem_bus.dmem_read_data); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1;
        r1 = $urandom | 32'h1;
        dmem_bus.dmem_address     = 32'h500;
        dmem_bus.dmem_read_enable = 1'b1;
        dmem_bus.dmem_read_mode   = 3'b010;
        dmem_bus.dmem_enable      = 1'b1;
        @(posedge clk); #1;
        mbus.mem_ack                = 1'b1;
        mbus.mem_rdata              = r1;
        dmem_bus.dmem_read_enable   = 1'b0;
        dmem_bus.dmem_write_enable  = 1'b1;
        dmem_bus.dmem_write_mode    = 3'b010;
        dmem_bus.dmem_address       = 32'h604;
        dmem_bus.dmem_write_data    = 32'h0BADCAFE;
        #1;
        n_cmp++; if (dmem_bus.dmem_read_data !== r1) begin n_err++; $display("FAIL b2b_rdata: got %h want %h", dmem_bus.dmem_read_data, r1); end
        @(posedge clk); #1;
        dmem_bus.dmem_enable       = 1'b0;
        dmem_bus.dmem_write_enable = 1'b0;
        mbus.mem_ack               = 1'b0;
        #1;
        n_cmp++; if (mbus.mem_req !== 1'b1) begin n_err++; $display("FAIL b2b_req: got %b want 1", mbus.mem_req); end
        n_cmp++; if ({mbus.mem_addr, mbus.mem_we, mbus.mem_wdata} !== {30'h181, 1'b1, 32'h0BADCAFE}) begin
            n_err++; $display("FAIL b2b_write: got addr=%h we=%b wdata=%h want 181/1/0badcafe", mbus.mem_addr, mbus.mem_we, mbus.mem_wdata);
        end
        n_cmp++; if (dmem_bus.dmem_wait !== 1'b1) begin n_err++; $display("FAIL b2b_wait: got %b want 1", dmem_bus.dmem_wait); end
        @(posedge clk); #1;
        mbus.mem_ack = 1'b1;
        @(posedge clk); #1;
        mbus.mem_ack = 1'b0;
        exp_rd = r1;
        n_cmp++; if (mbus.mem_req !== 1'b0) begin n_err++; $display("FAIL b2b_done: got %b want 0", mbus.mem_req); end
        n_cmp++; if (dmem_bus.dmem_read_data !== r1) begin n_err++; $display("FAIL b2b_hold: got %h want %h", dmem_bus.dmem_read_data, r1); end
    endtask

    task automatic test_timeout();
        int waits;
        run_access(1'b0, 1'b1, 3'b010, 32'h2F0, 32'h0, 1, 32'h55AA1234);
        dmem_bus.dmem_address     = 32'h300;
        dmem_bus.dmem_read_enable = 1'b1;
        dmem_bus.dmem_read_mode   = 3'b010;
        dmem_bus.dmem_enable      = 1'b1;
        @(posedge clk); #1;
        dmem_bus.dmem_enable      = 1'b0;
        dmem_bus.dmem_read_enable = 1'b0;
        waits = 0;
        for (int i = 0; i < 20 && dmem_bus.dmem_wait; i++) begin
            waits++;
            @(posedge clk); #1;
        end
        exp_rd = 32'h0;
        n_cmp++; if (waits !== 4) begin n_err++; $display("FAIL tmo_wait_cycles: got %0d want 4", waits); end
        n_cmp++; if (bus_error !== 1'b1) begin n_err++; $display("FAIL tmo_buserr: got %b want 1", bus_error); end
        n_cmp++; if (dmem_bus.dmem_read_data !== 32'h0) begin n_err++; $display("FAIL tmo_rdata: got %h want 0", dmem_bus.dmem_read_data); end
        n_cmp++; if (mbus.mem_req !== 1'b0) begin n_err++; $display("FAIL tmo_req: got %b want 0", mbus.mem_req); end
        @(posedge clk); #1;
        n_cmp++; if (bus_error !== 1'b0) begin n_err++; $display("FAIL tmo_pulse: got %b want 0", bus_error); end
    endtask

    task automatic test_reset_mid_access();
        run_access(1'b0, 1'b1, 3'b010, 32'h3F0, 32'h0, 0, 32'h77665544);
        dmem_bus.dmem_address     = 32'h400;
        dmem_bus.dmem_read_enable = 1'b1;
        dmem_bus.dmem_read_mode   = 3'b010;
        dmem_bus.dmem_enable      = 1'b1;
        @(posedge clk); #1;
        dmem_bus.dmem_enable      = 1'b0;
        dmem_bus.dmem_read_enable = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        exp_rd = 32'h0;
        n_cmp++; if ({mbus.mem_req, dmem_bus.dmem_wait} !== 2'b00) begin n_err++; $display("FAIL arst_drop: got req=%b wait=%b want 0/0", mbus.mem_req, dmem_bus.dmem_wait); end
        n_cmp++; if (dmem_bus.dmem_read_data !== 32'h0) begin n_err++; $display("FAIL arst_rdata: got %h want 0", dmem_bus.dmem_read_data); end
        @(posedge clk); #1;
        reset_n        = 1'b1;
        mbus.mem_ack   = 1'b1;
        mbus.mem_rdata = 32'hCAFEF00D;
        #1;
        n_cmp++; if (dmem_bus.dmem_read_data !== 32'h0) begin n_err++; $display("FAIL late_ack_comb: got %h want 0", dmem_bus.dmem_read_data); end
        @(posedge clk); #1;
        mbus.mem_ack = 1'b0;
        n_cmp++; if ({mbus.mem_req, dmem_bus.dmem_wait} !== 2'b00) begin n_err++; $display("FAIL late_ack_state: got req=%b wait=%b want 0/0", mbus.mem_req, dmem_bus.dmem_wait); end
        n_cmp++; if (dmem_bus.dmem_read_data !== 32'h0) begin n_err++; $display("FAIL late_ack_rdata: got %h want 0", dmem_bus.dmem_read_data); end
    endtask

`ifdef DMEM_MISALIGN_CHECK_EN
    task automatic test_misalign();
        run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 0, 32'h13572468);
        dmem_bus.dmem_address     = 32'h101;
        dmem_bus.dmem_read_enable = 1'b1;
        dmem_bus.dmem_read_mode   = 3'b010;
        dmem_bus.dmem_enable      = 1'b1;
        @(posedge clk); #1;
        dmem_bus.dmem_enable      = 1'b0;
        dmem_bus.dmem_read_enable = 1'b0;
        exp_rd = 32'h0;
        n_cmp++; if ({mbus.mem_req, dmem_bus.dmem_wait} !== 2'b00) begin n_err++; $display("FAIL mis_noreq: got req=%b wait=%b want 0/0", mbus.mem_req, dmem_bus.dmem_wait); end
        n_cmp++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL mis_pulse: got %b want 1", misaligned); end
        n_cmp++; if (dmem_bus.dmem_read_data !== 32'h0) begin n_err++; $display("FAIL mis_rdata: got %h want 0", dmem_bus.dmem_read_data); end
        @(posedge clk); #1;
        n_cmp++; if (misaligned !== 1'b0) begin n_err++; $display("FAIL mis_clear: got %b want 0", misaligned); end
    endtask
`endif

    task automatic test_random();
        int          sel;
        logic [31:0] addr;
        for (int n = 0; n < 60; n++) begin
            sel  = $urandom_range(1, 3);
            addr = $urandom;
`ifdef DMEM_MISALIGN_CHECK_EN
            addr[1:0] = 2'b00;
`endif
            run_access(sel[0], sel[1], 3'($urandom_range(0, 7)), addr, $urandom,
                       $urandom_range(0, 3), $urandom);
        end
    endtask

    initial begin
        reset_n                    = 1'b0;
        dmem_bus.dmem_address      = 32'h0;
        dmem_bus.dmem_enable       = 1'b0;
        dmem_bus.dmem_write_data   = 32'h0;
        dmem_bus.dmem_write_enable = 1'b0;
        dmem_bus.dmem_write_mode   = 3'b000;
        dmem_bus.dmem_read_enable  = 1'b0;
        dmem_bus.dmem_read_mode    = 3'b000;
        mbus.mem_ack               = 1'b0;
        mbus.mem_rdata             = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_zero_wait_load();
        test_store_byte();
        test_delayed_load();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
`ifdef DMEM_MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
